stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/lap/stop/reset controller for the BCD real-time clock counter chain (6 digits: mh ml sh sl msh msl). Takes two raw push-button levels, synchronises and edge-detects them, and runs a 4-state FSM. The FSM drives the chain's count enable and synchronous clear, freezes a lap snapshot for display, and flags a 60:00.00 wrap. Sits between the board buttons and the counter chain and display decoders.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each button synchroniser. Legal values are 2 to 4.
- `clk` in 1: system clock. Same clock as the counter chain.
- `aclr` in 1: asynchronous, active-high reset.
- `start_stop` in 1: raw button level, asynchronous to `clk`.
- `lap_reset` in 1: raw button level, asynchronous to `clk`.
- `wrap` in 1: one-cycle pulse, synchronous to `clk`. Comes from the minutes-high rollover.
- `live_digits` in 24: live counter value {mh,ml,sh,sl,msh,msl}, 4 bits BCD each.
- `count_en` out 1: enable for the counter chain.
- `count_clr` out 1: one-cycle synchronous clear for the counter chain.
- `disp_digits` out 24: value to display.
- `running` out 1: high in RUN or LAP.
- `lap_active` out 1: high in LAP.
- `overflow` out 1: sticky wrap flag.
- `state` out 2: current FSM state, for debug.

## Operation
- **Button path:** each button passes through a `SYNC_STAGES`-deep synchroniser, then a previous-value register.
  - `*_edge` = sync_out & ~prev.
  - Only rising edges act. Held levels and falling edges are ignored.
- **States:** IDLE=0, RUN=1, LAP=2, STOP=3.
- **Transitions:**
  - IDLE: ss_edge → RUN. lr_edge → IDLE, with a `count_clr` pulse.
  - RUN: ss_edge → STOP. lr_edge → LAP, and `live_digits` is captured into the lap register.
  - LAP: ss_edge → STOP. lr_edge → RUN, which releases the display.
  - STOP: ss_edge → RUN (resume). lr_edge → IDLE, with a `count_clr` pulse and `overflow` cleared.
- **Simultaneous edges:** ss_edge has priority. An lr_edge in the same cycle is discarded and not queued.
- **Outputs:**
  - `count_en` = (state==RUN) | (state==LAP). Decoded from the state register.
  - `disp_digits` = lap register when state==LAP, otherwise `live_digits`. Combinational mux.
  - `overflow` is set at the edge after a cycle with wrap & count_en. `wrap` is ignored while count_en=0.
  - `overflow` clears only on STOP→IDLE or `aclr`. If the clear and a set happen in the same cycle, the clear wins. This cannot occur, because count_en=0 in STOP.
- **Lap register:** loaded only on RUN→LAP. Holds its value otherwise.

## Timing
- **Reset (`aclr` high):** state=IDLE and all registers are 0. That gives `count_en`=0, `count_clr`=0, `overflow`=0, lap register=0, `disp_digits`=`live_digits`.
- **`aclr` mid-operation:** the FSM is forced to IDLE immediately, with no `count_clr` pulse. The counter chain shares `aclr`.
- **Button latency:** a raw level first sampled high at edge k appears at the synchroniser output after edge k+SYNC_STAGES−1. The state register updates at edge k+SYNC_STAGES. `count_en` follows in the same cycle.
- **Button held across reset release:** the prev register resets to 0, so the button yields exactly one edge, SYNC_STAGES cycles after release.
- **`count_clr`:** registered. High for exactly the first cycle in IDLE after a transition from STOP, or after an lr_edge taken in IDLE. Never high for two consecutive cycles.
- **Lap capture:** samples `live_digits` at the same clock edge that moves state to LAP.

## Structure
- **Shared package `stopwatch_pkg`:**
  - State localparams ST_IDLE, ST_RUN, ST_LAP, ST_STOP (2-bit).
  - DIGITS=6, DIGIT_W=4.
  - TIME_W = DIGITS*DIGIT_W = 24.
- **Sub-module `btn_edge`** (parameter SYNC_STAGES; ports clk, aclr, din, edge_out): synchroniser plus rising-edge detector. Instantiated twice.
- **Top level:** FSM next-state logic, lap register, overflow flag, count_clr register, display mux.

## Test plan
- **Reset, then start:** reset; raise `start_stop` for 5 cycles, SYNC_STAGES=2 → state=1 and `count_en`=1 exactly 2 cycles after the first sampling edge; a single transition only.
- **Lap capture:** in RUN, pulse `lap_reset` while `live_digits`=24'h012345 → state=2, `disp_digits` stays 24'h012345 as `live_digits` advances to 24'h012399; second lr pulse → state=1, display live.
- **Stop/reset:** RUN→STOP via ss, then lr → state=0, `count_clr` high for exactly 1 cycle, `count_en`=0 throughout.
- **Simultaneous edges:** raise both buttons on the same edge in RUN → state=3 (STOP), no lap capture, lr not acted on later.
- **Overflow:** `wrap` pulse in RUN → `overflow`=1 next cycle, held through STOP/RUN; `wrap` pulse in IDLE → no effect; STOP→IDLE → `overflow`=0.
- **Async reset mid-LAP:** assert `aclr` between clock edges while in LAP → state=0, `count_en`=0, lap reg=0 immediately, no `count_clr` pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch controller and its
// button front end.
package stopwatch_pkg;

    localparam int DIGITS  = 6;
    localparam int DIGIT_W = 4;
    localparam int TIME_W  = DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Push-button front end: multi-stage synchroniser followed by a rising-edge
// detector producing a one-cycle pulse per press.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic aclr,
    input  logic din,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev resets low so a button held through reset still yields one edge
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/lap/stop/reset controller for the BCD stopwatch counter chain: button
// edges drive a 4-state FSM that enables, clears and snapshots the chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              start_stop,
    input  logic              lap_reset,
    input  logic              wrap,
    input  logic [TIME_W-1:0] live_digits,
    output logic              count_en,
    output logic              count_clr,
    output logic [TIME_W-1:0] disp_digits,
    output logic              running,
    output logic              lap_active,
    output logic              overflow,
    output logic [1:0]        state
);

    state_t            state_q;
    state_t            state_d;
    logic              ss_edge;
    logic              lr_edge;
    logic              lr_take;
    logic [TIME_W-1:0] lap_q;
    logic              count_clr_q;
    logic              overflow_q;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_edge (
        .clk      (clk),
        .aclr     (aclr),
        .din      (start_stop),
        .edge_out (ss_edge)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lr_edge (
        .clk      (clk),
        .aclr     (aclr),
        .din      (lap_reset),
        .edge_out (lr_edge)
    );

    // start/stop wins a same-cycle collision; the lap/reset edge is dropped
    assign lr_take = lr_edge & ~ss_edge;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_edge) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                ST_LAP:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end else if (lr_edge) begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  state_d = ST_LAP;
                ST_LAP:  state_d = ST_RUN;
                ST_STOP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        count_en    = (state_q == ST_RUN) || (state_q == ST_LAP);
        running     = (state_q == ST_RUN) || (state_q == ST_LAP);
        lap_active  = (state_q == ST_LAP);
        disp_digits = (state_q == ST_LAP) ? lap_q : live_digits;
        state       = state_q;
    end

    // Clear pulse, lap snapshot and sticky wrap flag all key off the same edge
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count_clr_q <= 1'b0;
            lap_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            count_clr_q <= lr_take && ((state_q == ST_IDLE) || (state_q == ST_STOP));
            if (lr_take && (state_q == ST_RUN)) begin
                lap_q <= live_digits;
            end
            if (lr_take && (state_q == ST_STOP)) begin
                overflow_q <= 1'b0;
            end else if (wrap && count_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count_clr = count_clr_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized
// run against a transition-table reference model.
module tb_stopwatch_ctrl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap_reset = 1'b0;
    logic        wrap = 1'b0;
    logic [23:0] live_digits = 24'h0;
    logic        count_en;
    logic        count_clr;
    logic [23:0] disp_digits;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start_stop  (start_stop),
        .lap_reset   (lap_reset),
        .wrap        (wrap),
        .live_digits (live_digits),
        .count_en    (count_en),
        .count_clr   (count_clr),
        .disp_digits (disp_digits),
        .running     (running),
        .lap_active  (lap_active),
        .overflow    (overflow),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: button history windows plus per-button transition tables
    logic [1:0]  ss_next [4] = '{2'd1, 2'd3, 2'd3, 2'd1};
    logic [1:0]  lr_next [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
    logic [1:0]  m_state;
    logic [23:0] m_lap;
    logic        m_ovf;
    logic        m_clr;
    logic [SYNC:0] m_ss_hist;
    logic [SYNC:0] m_lr_hist;
    wire m_ss_ev   = m_ss_hist[SYNC-1] & ~m_ss_hist[SYNC];
    wire m_lr_ev   = m_lr_hist[SYNC-1] & ~m_lr_hist[SYNC];
    wire m_lr_take = m_lr_ev & ~m_ss_ev;

    always @(posedge clk or posedge aclr) begin
        if (aclr) begin
            m_state   <= 2'd0;
            m_lap     <= 24'h0;
            m_ovf     <= 1'b0;
            m_clr     <= 1'b0;
            m_ss_hist <= '0;
            m_lr_hist <= '0;
        end else begin
            m_ss_hist <= {m_ss_hist[SYNC-1:0], start_stop};
            m_lr_hist <= {m_lr_hist[SYNC-1:0], lap_reset};
            m_clr     <= m_lr_take && (m_state == 2'd0 || m_state == 2'd3);
            if (m_lr_take && m_state == 2'd3) m_ovf <= 1'b0;
            else if (wrap && (m_state == 2'd1 || m_state == 2'd2)) m_ovf <= 1'b1;
            if (m_lr_take && m_state == 2'd1) m_lap <= live_digits;
            if (m_ss_ev) m_state <= ss_next[m_state];
            else if (m_lr_ev) m_state <= lr_next[m_state];
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit use_lr);
        if (use_lr) lap_reset = 1'b1; else start_stop = 1'b1;
        wait_cycles(3);
        lap_reset  = 1'b0;
        start_stop = 1'b0;
        wait_cycles(SYNC + 2);
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        wait_cycles(3);
        live_digits = 24'h123456;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (count_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_count_en: got %b want 0", count_en); end
        n_cmp++; if (count_clr !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_count_clr: got %b want 0", count_clr); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (disp_digits !== 24'h123456) begin n_bad++; $display("[TB] FAIL reset_disp: got %h want 123456", disp_digits); end
        @(negedge clk);
        aclr = 1'b0;
        wait_cycles(2);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("[TB] FAIL post_reset_state: got %0d want 0", state); end
    endtask

    task automatic test_start();
        logic [1:0] exp_st;
        start_stop = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp_st = (i >= SYNC + 1) ? 2'd1 : 2'd0;
            n_cmp++; if (state !== exp_st) begin n_bad++; $display("[TB] FAIL start_latency_state: cycle %0d got %0d want %0d", i, state, exp_st); end
            n_cmp++; if (count_en !== exp_st[0]) begin n_bad++; $display("[TB] FAIL start_latency_en: cycle %0d got %b want %b", i, count_en, exp_st[0]); end
        end
        start_stop = 1'b0;
        wait_cycles(4);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL start_single_transition: got %0d want 1", state); end
    endtask

    task automatic test_lap();
        live_digits = 24'h012345;
        lap_reset = 1'b1;
        wait_cycles(SYNC + 1);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL lap_enter: got %0d want 2", state); end
        lap_reset = 1'b0;
        live_digits = 24'h012399;
        #1;
        n_cmp++; if (disp_digits !== 24'h012345) begin n_bad++; $display("[TB] FAIL lap_frozen: got %h want 012345", disp_digits); end
        wait_cycles(3);
        n_cmp++; if (disp_digits !== 24'h012345 || lap_active !== 1'b1) begin n_bad++; $display("[TB] FAIL lap_hold: got %h/%b want 012345/1", disp_digits, lap_active); end
        live_digits = 24'h024680;
        press(1'b1);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL lap_release_state: got %0d want 1", state); end
        n_cmp++; if (disp_digits !== 24'h024680) begin n_bad++; $display("[TB] FAIL lap_release_disp: got %h want 024680", disp_digits); end
    endtask

    task automatic test_stop_reset();
        press(1'b0);
        n_cmp++; if (state !== 2'd3 || count_en !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_enter: got %0d/%b want 3/0", state, count_en); end
        lap_reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_cmp++; if (count_clr !== (i == SYNC + 1)) begin n_bad++; $display("[TB] FAIL clr_pulse: cycle %0d got %b want %b", i, count_clr, (i == SYNC + 1)); end
            n_cmp++; if (count_en !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_count_en: cycle %0d got %b want 0", i, count_en); end
        end
        lap_reset = 1'b0;
        wait_cycles(2);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("[TB] FAIL stop_to_idle: got %0d want 0", state); end
    endtask

    task automatic test_simultaneous();
        press(1'b0);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL simul_setup: got %0d want 1", state); end
        start_stop = 1'b1;
        lap_reset  = 1'b1;
        wait_cycles(3);
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        wait_cycles(6);
        n_cmp++; if (state !== 2'd3 || lap_active !== 1'b0) begin n_bad++; $display("[TB] FAIL simul_priority: got %0d/%b want 3/0", state, lap_active); end
        press(1'b1);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("[TB] FAIL simul_cleanup: got %0d want 0", state); end
    endtask

    task automatic test_overflow();
        wrap = 1'b1;
        @(negedge clk);
        wrap = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_idle_ignored: got %b want 0", overflow); end
        press(1'b0);
        wrap = 1'b1;
        @(negedge clk);
        wrap = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
        press(1'b0);
        n_cmp++; if (overflow !== 1'b1 || state !== 2'd3) begin n_bad++; $display("[TB] FAIL ovf_hold_stop: got %b/%0d want 1/3", overflow, state); end
        press(1'b0);
        n_cmp++; if (overflow !== 1'b1 || state !== 2'd1) begin n_bad++; $display("[TB] FAIL ovf_hold_run: got %b/%0d want 1/1", overflow, state); end
        press(1'b0);
        press(1'b1);
        n_cmp++; if (overflow !== 1'b0 || state !== 2'd0) begin n_bad++; $display("[TB] FAIL ovf_clear: got %b/%0d want 0/0", overflow, state); end
    endtask

    task automatic test_async_reset();
        press(1'b0);
        press(1'b1);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL async_setup: got %0d want 2", state); end
        live_digits = 24'h054321;
        #2 aclr = 1'b1;
        #1;
        n_cmp++; if (state !== 2'd0 || count_en !== 1'b0) begin n_bad++; $display("[TB] FAIL async_state: got %0d/%b want 0/0", state, count_en); end
        n_cmp++; if (disp_digits !== 24'h054321 || count_clr !== 1'b0) begin n_bad++; $display("[TB] FAIL async_outputs: got %h/%b want 054321/0", disp_digits, count_clr); end
        @(negedge clk);
        aclr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (count_clr !== 1'b0 || state !== 2'd0) begin n_bad++; $display("[TB] FAIL async_no_clr: got %b/%0d want 0/0", count_clr, state); end
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_disp;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            exp_disp = (m_state == 2'd2) ? m_lap : live_digits;
            n_cmp++; if (state !== m_state) begin n_bad++; $display("[TB] FAIL rnd_state: cycle %0d got %0d want %0d", i, state, m_state); end
            n_cmp++; if (count_en !== (m_state == 2'd1 || m_state == 2'd2) || running !== count_en) begin n_bad++; $display("[TB] FAIL rnd_enable: cycle %0d got %b/%b state %0d", i, count_en, running, m_state); end
            n_cmp++; if (lap_active !== (m_state == 2'd2)) begin n_bad++; $display("[TB] FAIL rnd_lap_active: cycle %0d got %b want %b", i, lap_active, (m_state == 2'd2)); end
            n_cmp++; if (count_clr !== m_clr) begin n_bad++; $display("[TB] FAIL rnd_count_clr: cycle %0d got %b want %b", i, count_clr, m_clr); end
            n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("[TB] FAIL rnd_overflow: cycle %0d got %b want %b", i, overflow, m_ovf); end
            n_cmp++; if (disp_digits !== exp_disp) begin n_bad++; $display("[TB] FAIL rnd_disp: cycle %0d got %h want %h", i, disp_digits, exp_disp); end
            if ($urandom_range(0, 5) == 0) start_stop = ~start_stop;
            if ($urandom_range(0, 4) == 0) lap_reset = ~lap_reset;
            wrap        = ($urandom_range(0, 12) == 0);
            live_digits = 24'($urandom);
            aclr        = ($urandom_range(0, 150) == 0);
        end
        aclr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_stop_reset();
        test_simultaneous();
        test_overflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
